// File: rtl/operand_issue_stage.sv
// Decode/issue register: immediate, ALU operands and ALUSrc toward execute.
// Optional OPERAND_BYPASS_EN forwards writeback data into RS1/RS2.
module operand_issue_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instr,
  input  logic [XLEN-1:0]       rs1_data,
  input  logic [XLEN-1:0]       rs2_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       extension_signo,
  output logic [XLEN-1:0]       RS1,
  output logic [XLEN-1:0]       RS2,
  output logic                  ALUSrc,
  output logic [REG_ADDR_W-1:0] rd,
  output logic                  illegal,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data
);

  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_REG  = 7'b0110011;

  logic                  valid_q;
  logic [XLEN-1:0]       imm_q, imm_d;
  logic [XLEN-1:0]       op1_q, op1_d;
  logic [XLEN-1:0]       op2_q, op2_d;
  logic                  src_q, src_d;
  logic                  ill_q, ill_d;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [REG_ADDR_W-1:0] rs1_idx, rs2_idx;
  logic [6:0]            opc;
  logic                  cap;

  assign opc     = instr[6:0];
  assign rs1_idx = instr[19:15];
  assign rs2_idx = instr[24:20];

  assign in_ready = !valid_q | out_ready;
  assign cap      = in_valid & in_ready & !flush;

  always_comb begin
    imm_d = '0;
    src_d = 1'b0;
    ill_d = 1'b0;
    unique case (opc)
      OP_IMM, OP_LOAD, OP_JALR: begin
        imm_d = {{20{instr[31]}}, instr[31:20]};
        src_d = 1'b1;
      end
      OP_ST: begin
        imm_d = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        src_d = 1'b1;
      end
      OP_BR: begin
        imm_d = {{19{instr[31]}}, instr[31], instr[7],
                 instr[30:25], instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUI: begin
        imm_d = {instr[31:12], 12'b0};
        src_d = 1'b1;
      end
      OP_JAL: begin
        imm_d = {{11{instr[31]}}, instr[31], instr[19:12],
                 instr[20], instr[30:21], 1'b0};
        src_d = 1'b1;
      end
      OP_REG: ;
      default: ill_d = 1'b1;
    endcase
  end

`ifdef OPERAND_BYPASS_EN
  logic [REG_ADDR_W-1:0] rs1_idx_q, rs2_idx_q;
  logic                  byp1, byp2, hold1, hold2;

  assign byp1  = wb_en & (wb_rd != '0) & (wb_rd == rs1_idx);
  assign byp2  = wb_en & (wb_rd != '0) & (wb_rd == rs2_idx);
  assign hold1 = wb_en & (wb_rd != '0) & (wb_rd == rs1_idx_q);
  assign hold2 = wb_en & (wb_rd != '0) & (wb_rd == rs2_idx_q);

  always_comb begin
    op1_d = rs1_data;
    op2_d = rs2_data;
    if (byp1) op1_d = wb_data;
    if (byp2) op2_d = wb_data;
    if (rs1_idx == '0) op1_d = '0;
    if (rs2_idx == '0) op2_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_idx_q <= '0;
      rs2_idx_q <= '0;
    end else if (cap) begin
      rs1_idx_q <= rs1_idx;
      rs2_idx_q <= rs2_idx;
    end
  end
`else
  logic unused_wb;
  assign unused_wb = ^{wb_en, wb_rd, wb_data};

  always_comb begin
    op1_d = (rs1_idx == '0) ? '0 : rs1_data;
    op2_d = (rs2_idx == '0) ? '0 : rs2_data;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      imm_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      src_q   <= 1'b0;
      ill_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      if (flush)         valid_q <= 1'b0;
      else if (in_ready) valid_q <= in_valid;
      if (cap) begin
        imm_q <= imm_d;
        op1_q <= op1_d;
        op2_q <= op2_d;
        src_q <= src_d;
        ill_q <= ill_d;
        rd_q  <= instr[11:7];
      end
`ifdef OPERAND_BYPASS_EN
      // held operands track writebacks to their source registers
      else if (valid_q) begin
        if (hold1) op1_q <= wb_data;
        if (hold2) op2_q <= wb_data;
      end
`endif
    end
  end

  assign out_valid       = valid_q;
  assign extension_signo = imm_q;
  assign RS1             = op1_q;
  assign RS2             = op2_q;
  assign ALUSrc          = src_q;
  assign rd              = rd_q;
  assign illegal         = ill_q;

endmodule

// File: tb/tb_operand_issue_stage.sv
// Bench for operand_issue_stage: vector table + scoreboard queue.
// Also runs with OPERAND_BYPASS_EN defined.
module tb_operand_issue_stage;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        src;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] instr, rs1_data, rs2_data;
  logic        flush, out_valid, out_ready;
  logic [31:0] imm_o, rs1_o, rs2_o;
  logic        src_o, ill_o;
  logic [4:0]  rd_o;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int   total = 0;
  int   bad   = 0;
  vec_t sb[$];
  vec_t cur;
  vec_t tbl[10];

  always #5 clk = ~clk;

  operand_issue_stage dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .instr(instr),
    .rs1_data(rs1_data),
    .rs2_data(rs2_data),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .extension_signo(imm_o),
    .RS1(rs1_o),
    .RS2(rs2_o),
    .ALUSrc(src_o),
    .rd(rd_o),
    .illegal(ill_o),
    .wb_en(wb_en),
    .wb_rd(wb_rd),
    .wb_data(wb_data)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(logic [31:0] i, logic [31:0] a,
                              logic [31:0] b, logic [31:0] imm,
                              logic [31:0] e1, logic [31:0] e2,
                              logic src, logic [4:0] rd, logic ill);
    vec_t v;
    v.instr = i; v.a = a; v.b = b; v.imm = imm;
    v.e1 = e1; v.e2 = e2; v.src = src; v.rd = rd; v.ill = ill;
    return v;
  endfunction

  // scoreboard: push on capture, pop on transfer, drop on flushed hold
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_empty actual=issue required=none");
        end else begin
          vec_t e;
          e = sb.pop_front();
          chk("imm", imm_o, e.imm);
          chk("rs1", rs1_o, e.e1);
          chk("rs2", rs2_o, e.e2);
          chk("alusrc", {31'b0, src_o}, {31'b0, e.src});
          chk("rd", {27'b0, rd_o}, {27'b0, e.rd});
          chk("illegal", {31'b0, ill_o}, {31'b0, e.ill});
        end
      end else if (out_valid && flush && sb.size() != 0) begin
        void'(sb.pop_front());
      end
      if (in_valid && in_ready && !flush) sb.push_back(cur);
    end
  end

  task automatic drive(vec_t v);
    bit hs = 0;
    int n = 0;
    cur = v;
    instr = v.instr;
    rs1_data = v.a;
    rs2_data = v.b;
    in_valid = 1'b1;
    while (!hs && n < 20) begin
      @(negedge clk);
      hs = in_ready && !flush;
      @(posedge clk);
      #1;
      n++;
    end
    if (!hs) chk("drive_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", sb.size(), 32'd0);
  endtask

  initial begin
    logic [31:0] x1;
    logic [31:0] x2;
    vec_t v;
    tbl[0] = mk(32'hFFF08293, 32'd7, 32'h1234, 32'hFFFFFFFF,
                32'd7, 32'h1234, 1'b1, 5'd5, 1'b0);
    tbl[1] = mk(32'h00202423, 32'h55, 32'hDEAD, 32'd8,
                32'd0, 32'hDEAD, 1'b1, 5'd8, 1'b0);
    tbl[2] = mk(32'hFE208EE3, 32'h10, 32'h20, 32'hFFFFFFFC,
                32'h10, 32'h20, 1'b0, 5'd29, 1'b0);
    tbl[3] = mk(32'h12345537, 32'hA, 32'hB, 32'h12345000,
                32'hA, 32'hB, 1'b1, 5'd10, 1'b0);
    tbl[4] = mk(32'hFFFFF0EF, 32'h3, 32'h4, 32'hFFFFFFFE,
                32'h3, 32'h4, 1'b1, 5'd1, 1'b0);
    tbl[5] = mk(32'h002081B3, 32'h111, 32'h222, 32'd0,
                32'h111, 32'h222, 1'b0, 5'd3, 1'b0);
    tbl[6] = mk(32'h0000007F, 32'h9, 32'h8, 32'd0,
                32'd0, 32'd0, 1'b0, 5'd0, 1'b1);
    tbl[7] = mk(32'h80002303, 32'h77, 32'h66, 32'hFFFFF800,
                32'd0, 32'd0, 1'b1, 5'd6, 1'b0);
    tbl[8] = mk(32'hFE532FA3, 32'h5, 32'h6, 32'hFFFFFFFF,
                32'h5, 32'h6, 1'b1, 5'd31, 1'b0);
    tbl[9] = mk(32'h80000017, 32'h1, 32'h2, 32'h80000000,
                32'd0, 32'd0, 1'b1, 5'd0, 1'b0);

    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    wb_en = 1'b0;
    wb_rd = '0;
    wb_data = '0;
    cur = tbl[0];
    instr = tbl[0].instr;
    rs1_data = tbl[0].a;
    rs2_data = tbl[0].b;
    in_valid = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_imm", imm_o, 32'd0);
    chk("rst_rs1", rs1_o, 32'd0);
    chk("rst_rs2", rs2_o, 32'd0);
    chk("rst_alusrc", {31'b0, src_o}, 32'd0);
    chk("rst_rd", {27'b0, rd_o}, 32'd0);
    chk("rst_illegal", {31'b0, ill_o}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("first_issue", {31'b0, out_valid}, 32'd1);
    in_valid = 1'b0;

    for (int i = 1; i < 10; i++) drive(tbl[i]);
    drain();
    @(negedge clk);
    chk("handoff", {31'b0, out_valid}, 32'd0);

    // stall: sw held three cycles while beq waits upstream
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    drive(tbl[1]);
    cur = tbl[2];
    instr = tbl[2].instr;
    rs1_data = tbl[2].a;
    rs2_data = tbl[2].b;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_ready", {31'b0, in_ready}, 32'd0);
      chk("stall_valid", {31'b0, out_valid}, 32'd1);
      chk("stall_imm", imm_o, 32'd8);
      chk("stall_rs1", rs1_o, 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();

    // flush in the capture cycle
    cur = tbl[0];
    instr = tbl[0].instr;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_cap", {31'b0, out_valid}, 32'd0);
    chk("flush_sb", sb.size(), 32'd0);
    @(posedge clk);
    #1;

    // flush beats hold
    out_ready = 1'b0;
    drive(tbl[5]);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_hold", {31'b0, out_valid}, 32'd0);
    chk("flush_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // writeback while capturing and while holding
`ifdef OPERAND_BYPASS_EN
    x1 = 32'hA5;
    x2 = 32'h99;
`else
    x1 = 32'h11;
    x2 = 32'h22;
`endif
    v = mk(32'h002081B3, 32'h11, 32'h22, 32'd0,
           x1, x2, 1'b0, 5'd3, 1'b0);
    wb_en = 1'b1;
    wb_rd = 5'd2;
    wb_data = 32'h99;
    drive(v);
    wb_rd = 5'd1;
    wb_data = 32'hA5;
    @(posedge clk);
    #1;
    chk("wb_rs1", rs1_o, x1);
    chk("wb_rs2", rs2_o, x2);
    wb_rd = 5'd0;
    wb_data = 32'h77;
    @(posedge clk);
    #1;
    wb_en = 1'b0;
    chk("wb_x0", rs1_o, x1);
    chk("wb_hold_valid", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
